// File: rtl/hbm_arb_pkg.sv
// hbm_arb_pkg
// Shared definitions for the HBM job arbiter: the controller state type and
// the default requester count and beat-counter width used by the top level.
package hbm_arb_pkg;

  // Job controller states:
  //   IDLE    - waiting for any requester, round-robin grant
  //   CHECK   - validating the latched job bounds
  //   BUSY    - job running on the HBM read port, beats forwarded to owner
  //   RELEASE - job finished, waiting for the port to drop its done level
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_BEAT_W  = 24;

endpackage

// File: rtl/hbm_job_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin grant selection. The search starts at the
// requester after the most recent grant and wraps, so a requester that keeps
// asking is served after at most NUM_REQ-1 other grants.
//
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the most recent grant
//   grant      out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out IDX_W    index of the granted requester
//   grant_any  out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Walk the requesters in priority order last_grant+1 .. last_grant+NUM_REQ
  // (mod NUM_REQ); the first active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  assign grant_any = |req;

endmodule

// File: rtl/hbm_job_arbiter.sv
// hbm_job_arbiter
// Shares one HBM read port between NUM_REQ job requesters. A job is accepted
// round-robin, its address bounds are checked, then the port is started and
// every returned beat is forwarded (registered) to the job owner until the
// port reports done. All outputs are registered.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid / req_ready           per-requester job request / accept pulse
//   req_start_addr / req_end_addr   per-requester job byte bounds
//   rd_valid / rd_data              one-hot beat strobe to owner, shared data
//   job_done / job_beats            one-hot completion pulse and beat count
//   job_err                         one-hot rejected-job pulse (empty range)
//   port_start                      start level to the HBM read port
//   port_start_addr / port_end_addr job bounds to the port
//   port_done / port_valid_out / port_data_out  port status and read data
module hbm_job_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 256,
  parameter int BEAT_W     = DEF_BEAT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_start_addr,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_end_addr,
  output logic [NUM_REQ-1:0]                  rd_valid,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [NUM_REQ-1:0]                  job_done,
  output logic [NUM_REQ-1:0]                  job_err,
  output logic [BEAT_W-1:0]                   job_beats,
  output logic                                port_start,
  output logic [ADDR_WIDTH-1:0]               port_start_addr,
  output logic [ADDR_WIDTH-1:0]               port_end_addr,
  input  logic                                port_done,
  input  logic                                port_valid_out,
  input  logic [DATA_WIDTH-1:0]               port_data_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e state, state_d;

  logic [IDX_W-1:0]      last_grant, last_grant_d;
  logic [IDX_W-1:0]      owner, owner_d;
  logic [BEAT_W-1:0]     beats, beats_d, beats_inc;

  logic [NUM_REQ-1:0]    req_ready_d;
  logic [NUM_REQ-1:0]    rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [NUM_REQ-1:0]    job_done_d;
  logic [NUM_REQ-1:0]    job_err_d;
  logic [BEAT_W-1:0]     job_beats_d;
  logic                  port_start_d;
  logic [ADDR_WIDTH-1:0] port_start_addr_d;
  logic [ADDR_WIDTH-1:0] port_end_addr_d;

  logic [NUM_REQ-1:0]    rr_grant;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .grant_idx  (rr_idx),
    .grant_any  (rr_any)
  );

  // The beat counter sticks at all-ones instead of wrapping, so a huge job
  // reports "at least this many" rather than a small bogus count.
  assign beats_inc = (beats == {BEAT_W{1'b1}}) ? beats : beats + BEAT_W'(1);

  // Next-state and next-output logic. Pulse outputs default to zero each
  // cycle; bounds, owner and port_start hold unless a state changes them.
  always_comb begin
    state_d           = state;
    last_grant_d      = last_grant;
    owner_d           = owner;
    beats_d           = beats;
    req_ready_d       = '0;
    rd_valid_d        = '0;
    rd_data_d         = rd_data;
    job_done_d        = '0;
    job_err_d         = '0;
    job_beats_d       = '0;
    port_start_d      = port_start;
    port_start_addr_d = port_start_addr;
    port_end_addr_d   = port_end_addr;

    unique case (state)
      IDLE: begin
        if (rr_any) begin
          req_ready_d       = rr_grant;
          owner_d           = rr_idx;
          last_grant_d      = rr_idx;
          port_start_addr_d = req_start_addr[rr_idx];
          port_end_addr_d   = req_end_addr[rr_idx];
          beats_d           = '0;
          state_d           = CHECK;
        end
      end

      CHECK: begin
        // An empty or inverted range never reaches the port.
        if (port_end_addr <= port_start_addr) begin
          job_err_d[owner] = 1'b1;
          state_d          = IDLE;
        end else begin
          port_start_d = 1'b1;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        if (port_valid_out) begin
          rd_valid_d[owner] = 1'b1;
          rd_data_d         = port_data_out;
          beats_d           = beats_inc;
        end
        // A beat arriving together with done is still forwarded and counted;
        // the port is expected to raise done only after its final beat.
        if (port_done) begin
          port_start_d     = 1'b0;
          job_done_d[owner] = 1'b1;
          job_beats_d      = beats_d;
          state_d          = RELEASE;
        end
      end

      RELEASE: begin
        // Hold off new grants until the port has left its done state.
        if (!port_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset leaves requester 0 with top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= IDX_W'(NUM_REQ - 1);
      owner           <= '0;
      beats           <= '0;
      req_ready       <= '0;
      rd_valid        <= '0;
      rd_data         <= '0;
      job_done        <= '0;
      job_err         <= '0;
      job_beats       <= '0;
      port_start      <= 1'b0;
      port_start_addr <= '0;
      port_end_addr   <= '0;
    end else begin
      state           <= state_d;
      last_grant      <= last_grant_d;
      owner           <= owner_d;
      beats           <= beats_d;
      req_ready       <= req_ready_d;
      rd_valid        <= rd_valid_d;
      rd_data         <= rd_data_d;
      job_done        <= job_done_d;
      job_err         <= job_err_d;
      job_beats       <= job_beats_d;
      port_start      <= port_start_d;
      port_start_addr <= port_start_addr_d;
      port_end_addr   <= port_end_addr_d;
    end
  end

endmodule

// File: tb/tb_hbm_job_arbiter.sv
// tb_hbm_job_arbiter
// Directed bench for hbm_job_arbiter. The bench plays the HBM port: every
// beat it presents during a job is pushed to a scoreboard with its expected
// owner, and a monitor pops and compares on each rd_valid.
module tb_hbm_job_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 34;
  localparam int DATA_WIDTH = 256;
  localparam int BEAT_W     = 24;

  logic                               clk;
  logic                               rst;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_start_addr;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_end_addr;
  logic [NUM_REQ-1:0]                 rd_valid;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic [NUM_REQ-1:0]                 job_done;
  logic [NUM_REQ-1:0]                 job_err;
  logic [BEAT_W-1:0]                  job_beats;
  logic                               port_start;
  logic [ADDR_WIDTH-1:0]              port_start_addr;
  logic [ADDR_WIDTH-1:0]              port_end_addr;
  logic                               port_done;
  logic                               port_valid_out;
  logic [DATA_WIDTH-1:0]              port_data_out;

  hbm_job_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BEAT_W     (BEAT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_start_addr  (req_start_addr),
    .req_end_addr    (req_end_addr),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .job_done        (job_done),
    .job_err         (job_err),
    .job_beats       (job_beats),
    .port_start      (port_start),
    .port_start_addr (port_start_addr),
    .port_end_addr   (port_end_addr),
    .port_done       (port_done),
    .port_valid_out  (port_valid_out),
    .port_data_out   (port_data_out)
  );

  typedef struct packed {
    logic [1:0]            owner;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t mon_beat;

  int tests_run    = 0;
  int tests_failed = 0;
  int onehot_viol  = 0;
  int done_seen[NUM_REQ];
  int err_seen[NUM_REQ];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] observed,
                             input logic [DATA_WIDTH-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic requestJob(input int idx, input logic [ADDR_WIDTH-1:0] s,
                            input logic [ADDR_WIDTH-1:0] e);
    req_start_addr[idx] = s;
    req_end_addr[idx]   = e;
    req_valid[idx]      = 1'b1;
  endtask

  // Waits (bounded) for an accept pulse and checks it went to exp_idx.
  task automatic waitReady(input int exp_idx, input bit drop);
    int cycles;
    cycles = 0;
    tick();
    while (req_ready == '0 && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("grant", DATA_WIDTH'(req_ready), DATA_WIDTH'(onehot(exp_idx)));
    if (drop) req_valid[exp_idx] = 1'b0;
  endtask

  // Plays nbeats port beats for the given owner; optional idle cycle before
  // beat gap_at. Returns on the cycle the last beat's rd_valid is visible.
  task automatic applyStimulus(input int owner, input int nbeats, input int gap_at);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin
        port_valid_out = 1'b0;
        tick();
      end
      for (int w = 0; w < DATA_WIDTH / 32; w++) port_data_out[w*32 +: 32] = $urandom();
      port_valid_out = 1'b1;
      b.owner = 2'(owner);
      b.data  = port_data_out;
      sb.push_back(b);
      tick();
    end
    port_valid_out = 1'b0;
  endtask

  // Raises port_done and checks the completion pulse one cycle later.
  task automatic finishJob(input int owner, input int exp_beats);
    port_done = 1'b1;
    tick();
    checkOutput("job_done", DATA_WIDTH'(job_done), DATA_WIDTH'(onehot(owner)));
    checkOutput("job_beats", DATA_WIDTH'(job_beats), DATA_WIDTH'(exp_beats));
    checkOutput("port_start drop", DATA_WIDTH'(port_start), '0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " req_ready"}, DATA_WIDTH'(req_ready), '0);
    checkOutput({tag, " rd_valid"}, DATA_WIDTH'(rd_valid), '0);
    checkOutput({tag, " rd_data"}, rd_data, '0);
    checkOutput({tag, " job_done"}, DATA_WIDTH'(job_done), '0);
    checkOutput({tag, " job_err"}, DATA_WIDTH'(job_err), '0);
    checkOutput({tag, " job_beats"}, DATA_WIDTH'(job_beats), '0);
    checkOutput({tag, " port_start"}, DATA_WIDTH'(port_start), '0);
    checkOutput({tag, " port_start_addr"}, DATA_WIDTH'(port_start_addr), '0);
    checkOutput({tag, " port_end_addr"}, DATA_WIDTH'(port_end_addr), '0);
  endtask

  // Output monitor: scoreboard compare on every beat, event tallies, and a
  // running count of cycles where a one-hot output had several bits set.
  always @(negedge clk) begin
    if (!$onehot0(req_ready) || !$onehot0(rd_valid) ||
        !$onehot0(job_done) || !$onehot0(job_err)) onehot_viol++;
    if (rd_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected rd_valid", DATA_WIDTH'(rd_valid), '0);
      end else begin
        mon_beat = sb.pop_front();
        checkOutput("rd_valid owner", DATA_WIDTH'(rd_valid), DATA_WIDTH'(onehot(int'(mon_beat.owner))));
        checkOutput("rd_data", rd_data, mon_beat.data);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (job_done[i]) done_seen[i]++;
      if (job_err[i]) err_seen[i]++;
    end
  end

  initial begin
    automatic int order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NUM_REQ; i++) begin
      done_seen[i] = 0;
      err_seen[i]  = 0;
    end
    rst            = 1'b1;
    req_valid      = '0;
    req_start_addr = '0;
    req_end_addr   = '0;
    port_done      = 1'b0;
    port_valid_out = 1'b0;
    port_data_out  = '0;
    tick(3);
    rst = 1'b0;
    checkAllZero("reset");

    // Stray port beats while idle must not reach any requester.
    port_valid_out = 1'b1;
    port_data_out  = {8{32'hDEAD_BEEF}};
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle stray rd_valid", DATA_WIDTH'(rd_valid), '0);
    end
    port_valid_out = 1'b0;

    // Requester 0, 0x0..0x4000, two 256-beat bursts.
    requestJob(0, 34'h0, 34'h4000);
    waitReady(0, 1'b1);
    checkOutput("latched start", DATA_WIDTH'(port_start_addr), DATA_WIDTH'(34'h0));
    checkOutput("latched end", DATA_WIDTH'(port_end_addr), DATA_WIDTH'(34'h4000));
    checkOutput("port_start in CHECK", DATA_WIDTH'(port_start), '0);
    tick();
    checkOutput("port_start T+2", DATA_WIDTH'(port_start), DATA_WIDTH'(1));
    applyStimulus(0, 512, 256);
    checkOutput("end held in BUSY", DATA_WIDTH'(port_end_addr), DATA_WIDTH'(34'h4000));
    finishJob(0, 512);
    checkOutput("end held in RELEASE", DATA_WIDTH'(port_end_addr), DATA_WIDTH'(34'h4000));
    port_done = 1'b0;
    tick();

    // Empty range from requester 2 is rejected without touching the port.
    requestJob(2, 34'h1000, 34'h1000);
    waitReady(2, 1'b1);
    tick();
    checkOutput("job_err", DATA_WIDTH'(job_err), DATA_WIDTH'(onehot(2)));
    checkOutput("port_start on err", DATA_WIDTH'(port_start), '0);
    tick();
    checkOutput("job_err pulse", DATA_WIDTH'(job_err), '0);
    checkOutput("port_start after err", DATA_WIDTH'(port_start), '0);
    checkOutput("no done for err", DATA_WIDTH'(done_seen[2]), '0);

    // port_done held high after completion blocks the pending requester 1.
    requestJob(0, 34'h100, 34'h200);
    waitReady(0, 1'b1);
    tick();
    applyStimulus(0, 3, -1);
    requestJob(1, 34'h2000, 34'h3000);
    finishJob(0, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("no grant while done", DATA_WIDTH'(req_ready), '0);
    end
    port_done = 1'b0;
    waitReady(1, 1'b1);
    tick();
    applyStimulus(1, 1, -1);
    finishJob(1, 1);
    port_done = 1'b0;
    tick();

    // All four requesters held: fair rotation 0,1,2,3,0 after reset.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) requestJob(i, 34'h40 * i, 34'h40 * i + 34'h40);
    for (int k = 0; k < 5; k++) begin
      waitReady(order[k], 1'b0);
      if (k == 4) req_valid = '0;
      tick();
      applyStimulus(order[k], 1, -1);
      finishJob(order[k], 1);
      port_done = 1'b0;
    end
    tick();

    // Reset in the middle of a job from requester 2 after 10 beats.
    requestJob(2, 34'h8000, 34'h9000);
    waitReady(2, 1'b1);
    tick();
    applyStimulus(2, 10, -1);
    rst = 1'b1;
    tick();
    checkAllZero("mid-job reset");
    rst = 1'b0;
    requestJob(0, 34'h10, 34'h20);
    requestJob(3, 34'h30, 34'h40);
    waitReady(0, 1'b1);
    req_valid[3] = 1'b0;
    tick();
    finishJob(0, 0);
    port_done = 1'b0;
    tick(2);

    checkOutput("aborted job no done", DATA_WIDTH'(done_seen[2]), DATA_WIDTH'(1));
    checkOutput("done count req0", DATA_WIDTH'(done_seen[0]), DATA_WIDTH'(5));
    checkOutput("done count req1", DATA_WIDTH'(done_seen[1]), DATA_WIDTH'(2));
    checkOutput("err count req2", DATA_WIDTH'(err_seen[2]), DATA_WIDTH'(1));
    checkOutput("scoreboard drained", DATA_WIDTH'(sb.size()), '0);
    checkOutput("one-hot outputs", DATA_WIDTH'(onehot_viol), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
